lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Multi-cycle load/store sequencer between the RV32I core datapath and the data-memory bus. It consumes the decoder's MemRead/MemWrite/MemSize/MemSign and the ALU address, and stalls the core while the bus transaction runs. It issues a word-aligned bus request with byte enables, replicates store data across lanes, and extracts and sign- or zero-extends load data. It also detects misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 255, maximum cycles spent in REQ without bus_ack before the access is aborted (≥1).
CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_read  in  1  load request from decoder
mem_write  in  1  store request from decoder
mem_size  in  2  00=byte, 01=half, 10=word, 11 treated as word
mem_sign  in  1  1=sign-extend load, 0=zero-extend
addr  in  32  byte address from ALU
wdata  in  32  store data (rs2)
rdata  out  32  extended load result, registered
stall  out  1  core must hold PC/pipeline while 1
misalign  out  1  one-cycle pulse: misaligned access rejected
timeout  out  1  one-cycle pulse: bus access aborted
bus_req  out  1  bus request, registered
bus_we  out  1  1=write
bus_addr  out  32  word address, {addr[31:2],2'b00}
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated store data
bus_rdata  in  32  bus read word
bus_ack  in  1  bus completion, one cycle

Behaviour:
- Reset (async, rst_n=0): state=IDLE. bus_req, bus_we, bus_addr, bus_be, bus_wdata, rdata, misalign and timeout are all 0. Any in-flight bus_req drops immediately.
- States: IDLE, REQ, DONE.
- access = mem_read | mem_write. If both are 1, write wins and bus_we=1.
- Misaligned condition:
  - half with addr[0]=1;
  - word (size 10 or 11) with addr[1:0]≠00.
- stall (combinational) = (IDLE & access & aligned) | REQ. stall=0 in DONE.
- IDLE, access & aligned:
  - Capture bus_we, bus_addr, bus_be, bus_wdata, addr[1:0], mem_size and mem_sign into registers.
  - Set bus_req=1 and go to REQ. Clear the timeout counter.
- IDLE, access & misaligned:
  - No bus request, stall=0.
  - Next cycle: misalign=1 and rdata=0. A store is suppressed.
  - Stay in IDLE.
- IDLE, no access: remain; rdata holds its last value.
- REQ:
  - Hold bus_req and all bus outputs stable; increment the counter each cycle.
  - On bus_ack: if a load, rdata ← extend(bus_rdata). Drop bus_req and go to DONE.
  - If the counter reaches TIMEOUT-1 without ack: drop bus_req, rdata ← 0, pulse timeout in the DONE cycle, go to DONE.
  - An ack arriving in the same cycle as the timeout wins; no timeout pulse.
- DONE: stall=0 so the core advances this edge. A new access is not accepted (the instruction is still present). Go to IDLE unconditionally.
- Byte enables:
  - byte → 4'b0001<<addr[1:0];
  - half → addr[1]?1100:0011;
  - word → 1111.
- Store data:
  - byte → {4{wdata[7:0]}};
  - half → {2{wdata[15:0]}};
  - word → wdata.
- Load extract:
  - byte lane = bus_rdata[8*a+7:8*a], a = captured addr[1:0];
  - half = addr[1] ? [31:16] : [15:0];
  - extend with the sign bit if mem_sign=1, else with zeros.
- Latency: an aligned access with ack in the first REQ cycle stalls 2 cycles (IDLE-detect, REQ); the core proceeds on the 3rd (DONE). Each extra ack-wait cycle adds 1.
- bus_ack outside REQ is ignored.
- A mid-transaction reset aborts with no ack wait. Retry after reset is the core's responsibility.

Test Plan:
- LB mem_sign=1 at addr 0x103, bus_rdata=0x80000000, ack on first REQ cycle → bus_addr=0x100, bus_be=1000, stall=1 for 2 cycles, rdata=0xFFFFFF80; LBU same → rdata=0x00000080.
- SH at addr 0x202, wdata=0x1234ABCD → bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD, bus_addr=0x200; LHU addr 0x202, bus_rdata=0x8001FFFF → rdata=0x00008001.
- LW at addr 0x102 → bus_req never asserts, stall=0, misalign pulses 1 cycle, rdata=0; SW at 0x101 → no bus write.
- LW aligned, ack delayed 5 cycles → bus_req high 6 cycles with bus outputs stable; stall high 7 cycles; DONE 1 cycle then IDLE.
- TIMEOUT=4, no ack → bus_req high 4 cycles, then timeout pulse and rdata=0; ack injected in IDLE afterwards → ignored.
- rst_n low in the 2nd REQ cycle → bus_req=0 immediately; after release state=IDLE and a fresh LW completes normally.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns a decoded memory op into a single word-aligned
// bus transaction, stalls the core while it runs, and returns extended load data.
module lsu_ctrl #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_sign,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misalign,
   output logic        timeout,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       off_q;
   logic [1:0]       size_q;
   logic             sign_q;

   logic             access;
   logic             misal;
   logic [3:0]       be_n;
   logic [31:0]      wdata_n;
   logic [31:0]      shifted;
   logic [7:0]       lane8;
   logic [15:0]      lane16;
   logic [31:0]      ext;

   assign access = mem_read | mem_write;
   assign stall  = ((state == IDLE) && access && !misal) || (state == REQ);

   // alignment check, byte enables and lane-replicated store data for the incoming op
   always_comb begin
      misal   = 1'b0;
      be_n    = 4'b1111;
      wdata_n = wdata;
      case (mem_size)
         2'b00: begin
            be_n    = 4'b0001 << addr[1:0];
            wdata_n = {4{wdata[7:0]}};
         end
         2'b01: begin
            misal   = addr[0];
            be_n    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{wdata[15:0]}};
         end
         default: misal = |addr[1:0];
      endcase
   end

   // pick the addressed lane of the returned word and extend it
   always_comb begin
      shifted = bus_rdata >> {off_q, 3'b000};
      lane8   = shifted[7:0];
      lane16  = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (size_q)
         2'b00:   ext = {{24{sign_q & lane8[7]}}, lane8};
         2'b01:   ext = {{16{sign_q & lane16[15]}}, lane16};
         default: ext = bus_rdata;
      endcase
   end

   // sequencer: IDLE accepts, REQ waits for ack or timeout, DONE lets the core advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         off_q     <= 2'b00;
         size_q    <= 2'b00;
         sign_q    <= 1'b0;
         rdata     <= '0;
         misalign  <= 1'b0;
         timeout   <= 1'b0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_be    <= '0;
         bus_wdata <= '0;
      end else begin
         misalign <= 1'b0;
         timeout  <= 1'b0;
         case (state)
            IDLE: begin
               if (access && !misal) begin
                  bus_we    <= mem_write;
                  bus_addr  <= {addr[31:2], 2'b00};
                  bus_be    <= be_n;
                  bus_wdata <= wdata_n;
                  off_q     <= addr[1:0];
                  size_q    <= mem_size;
                  sign_q    <= mem_sign;
                  bus_req   <= 1'b1;
                  cnt       <= '0;
                  state     <= REQ;
               end else if (access) begin
                  // rejected op: no bus traffic, a store is simply dropped
                  misalign <= 1'b1;
                  rdata    <= '0;
               end
            end
            REQ: begin
               // ack has priority over a timeout in the same cycle
               if (bus_ack) begin
                  if (!bus_we) rdata <= ext;
                  bus_req <= 1'b0;
                  state   <= DONE;
               end else if (cnt == CNT_LAST) begin
                  bus_req <= 1'b0;
                  rdata   <= '0;
                  timeout <= 1'b1;
                  state   <= DONE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: scoreboard of expected bus/load results per access,
// plus a short-timeout instance for the abort path.
module tb_lsu_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rst_to_n = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0, mem_sign = 1'b0, bus_ack = 1'b0;
   logic [1:0]  mem_size = 2'b00;
   logic [31:0] addr = '0, wdata = '0, bus_rdata = '0;

   logic [31:0] rdata, bus_addr, bus_wdata;
   logic        stall, misalign, timeout, bus_req, bus_we;
   logic [3:0]  bus_be;

   logic [31:0] t_rdata, t_bus_addr, t_bus_wdata;
   logic        t_stall, t_misalign, t_timeout, t_bus_req, t_bus_we;
   logic [3:0]  t_bus_be;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic        we;
      logic [31:0] wd;
      logic [31:0] rd;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   logic [31:0] last_rd;

   lsu_ctrl #(.TIMEOUT(16), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_sign(mem_sign), .addr(addr), .wdata(wdata),
      .rdata(rdata), .stall(stall), .misalign(misalign), .timeout(timeout),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack));

   lsu_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut_to (
      .clk(clk), .rst_n(rst_to_n), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_sign(mem_sign), .addr(addr), .wdata(wdata),
      .rdata(t_rdata), .stall(t_stall), .misalign(t_misalign), .timeout(t_timeout),
      .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_addr(t_bus_addr), .bus_be(t_bus_be),
      .bus_wdata(t_bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] o);
      if (sz == 2'b00) return 4'b0001 << o;
      if (sz == 2'b01) return o[1] ? 4'b1100 : 4'b0011;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] m_wd(input logic [1:0] sz, input logic [31:0] d);
      if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
      if (sz == 2'b01) return {d[15:0], d[15:0]};
      return d;
   endfunction

   function automatic logic [31:0] m_rd(input logic [1:0] sz, input logic sg,
                                        input logic [1:0] o, input logic [31:0] d);
      int io;
      logic [7:0]  b;
      logic [15:0] h;
      io = int'(o);
      b  = d[io*8 +: 8];
      h  = o[1] ? d[31:16] : d[15:0];
      if (sz == 2'b00) return sg ? {{24{b[7]}}, b} : {24'h0, b};
      if (sz == 2'b01) return sg ? {{16{h[15]}}, h} : {16'h0, h};
      return d;
   endfunction

   // one aligned access on the main instance; ack arrives in REQ cycle number dly
   task automatic run(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                      input int dly, input exp_t e_in);
      exp_t e;
      int nst, nreq;
      e = e_in;
      sbq.push_back(e_in);
      mem_read = rd; mem_write = wr; mem_size = sz; mem_sign = sg;
      addr = a; wdata = wd; bus_rdata = brd; bus_ack = 1'b0;
      nst = 0; nreq = 0;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (!stall) break;
         nst++;
         if (bus_req) begin
            if (nreq == 0) e = sbq.pop_front();
            chk("bus_addr", bus_addr, e.addr);
            chk("bus_be", 32'(bus_be), 32'(e.be));
            chk("bus_we", 32'(bus_we), 32'(e.we));
            chk("bus_wdata", bus_wdata, e.wd);
            bus_ack = (nreq == dly);
            nreq++;
         end
         @(posedge clk); #1;
         bus_ack = 1'b0;
      end
      if (nreq == 0 && sbq.size() > 0) void'(sbq.pop_front());
      chk("stall_cycles", 32'(nst), 32'(dly + 2));
      chk("req_cycles", 32'(nreq), 32'(dly + 1));
      chk("rdata", rdata, e.rd);
      chk("done_timeout", 32'(timeout), 32'd0);
      chk("done_bus_req", 32'(bus_req), 32'd0);
      last_rd = e.rd;
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      chk("idle_stall", 32'(stall), 32'd0);
   endtask

   // misaligned op: rejected without a bus request, misalign pulses next cycle
   task automatic mis(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] a);
      mem_read = rd; mem_write = wr; mem_size = sz; addr = a; wdata = 32'hCAFEF00D;
      #1;
      chk("mis_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      chk("mis_pulse", 32'(misalign), 32'd1);
      chk("mis_rdata", rdata, 32'd0);
      chk("mis_bus_req", 32'(bus_req), 32'd0);
      mem_read = 1'b0; mem_write = 1'b0;
      @(posedge clk); #1;
      chk("mis_pulse_end", 32'(misalign), 32'd0);
      chk("mis_bus_req2", 32'(bus_req), 32'd0);
      last_rd = 32'd0;
   endtask

   initial begin
      int nst, nreq;
      logic [1:0]  sz, o;
      logic        wr, sg;
      logic [31:0] wd, brd, a;
      int          dly;

      // reset values
      #12;
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_we", 32'(bus_we), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_be", 32'(bus_be), 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      chk("rst_misalign", 32'(misalign), 32'd0);
      chk("rst_timeout", 32'(timeout), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1; rst_to_n = 1'b1;
      last_rd = 32'd0;

      // LB / LBU at 0x103
      run(1'b1, 1'b0, 2'b00, 1'b1, 32'h103, 32'hA5, 32'h80000000, 0,
          '{addr: 32'h100, be: 4'b1000, we: 1'b0, wd: 32'hA5A5A5A5, rd: 32'hFFFFFF80});
      run(1'b1, 1'b0, 2'b00, 1'b0, 32'h103, 32'hA5, 32'h80000000, 0,
          '{addr: 32'h100, be: 4'b1000, we: 1'b0, wd: 32'hA5A5A5A5, rd: 32'h00000080});

      // timeout path on the TIMEOUT=4 instance, main instance parked in reset
      rst_n = 1'b0;
      mem_read = 1'b1; mem_size = 2'b10; mem_sign = 1'b0; addr = 32'h40;
      bus_rdata = 32'h80000000; bus_ack = 1'b0;
      nst = 0; nreq = 0;
      for (int c = 0; c < 20; c++) begin
         #1;
         if (!t_stall) break;
         nst++;
         if (t_bus_req) nreq++;
         @(posedge clk); #1;
      end
      chk("to_req_cycles", 32'(nreq), 32'd4);
      chk("to_stall_cycles", 32'(nst), 32'd5);
      chk("to_pulse", 32'(t_timeout), 32'd1);
      chk("to_rdata", t_rdata, 32'd0);
      chk("to_bus_req", 32'(t_bus_req), 32'd0);
      @(posedge clk); #1;
      mem_read = 1'b0; bus_ack = 1'b1;
      #1;
      chk("to_pulse_end", 32'(t_timeout), 32'd0);
      @(posedge clk); #1;
      bus_ack = 1'b0;
      chk("to_idle_ack_req", 32'(t_bus_req), 32'd0);
      chk("to_idle_ack_rdata", t_rdata, 32'd0);
      chk("to_idle_ack_stall", 32'(t_stall), 32'd0);
      rst_to_n = 1'b0;
      rst_n = 1'b1;
      last_rd = 32'd0;

      // SH then LHU at 0x202
      run(1'b0, 1'b1, 2'b01, 1'b0, 32'h202, 32'h1234ABCD, 32'h0, 0,
          '{addr: 32'h200, be: 4'b1100, we: 1'b1, wd: 32'hABCDABCD, rd: last_rd});
      run(1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'h0, 32'h8001FFFF, 0,
          '{addr: 32'h200, be: 4'b1100, we: 1'b0, wd: 32'h0, rd: 32'h00008001});

      // misaligned word/half
      mis(1'b1, 1'b0, 2'b10, 32'h102);
      mis(1'b0, 1'b1, 2'b10, 32'h101);
      mis(1'b0, 1'b1, 2'b01, 32'h203);

      // read+write together: write wins
      run(1'b1, 1'b1, 2'b00, 1'b0, 32'h0, 32'h5A, 32'hFFFFFFFF, 0,
          '{addr: 32'h0, be: 4'b0001, we: 1'b1, wd: 32'h5A5A5A5A, rd: last_rd});

      // LW with 5 extra ack-wait cycles
      run(1'b1, 1'b0, 2'b10, 1'b0, 32'h300, 32'h0, 32'hDEADBEEF, 5,
          '{addr: 32'h300, be: 4'b1111, we: 1'b0, wd: 32'h0, rd: 32'hDEADBEEF});

      // reset in the 2nd REQ cycle
      mem_read = 1'b1; mem_size = 2'b10; addr = 32'h400; bus_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_req_active", 32'(bus_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_bus_req", 32'(bus_req), 32'd0);
      chk("mid_rst_bus_addr", bus_addr, 32'd0);
      chk("mid_rst_rdata", rdata, 32'd0);
      mem_read = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      last_rd = 32'd0;
      run(1'b1, 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'h11223344, 1,
          '{addr: 32'h500, be: 4'b1111, we: 1'b0, wd: 32'h0, rd: 32'h11223344});

      // mixed aligned accesses against the reference model
      for (int i = 0; i < 10; i++) begin
         sz  = 2'($urandom_range(0, 3));
         o   = 2'($urandom_range(0, 3));
         if (sz == 2'b01) o[0] = 1'b0;
         if (sz[1]) o = 2'b00;
         wr  = 1'($urandom_range(0, 1));
         sg  = 1'($urandom_range(0, 1));
         wd  = $urandom;
         brd = $urandom;
         dly = $urandom_range(0, 2);
         a   = {20'h0, 10'($urandom_range(0, 1023)), o};
         run(~wr, wr, sz, sg, a, wd, brd, dly,
             '{addr: {a[31:2], 2'b00}, be: m_be(sz, o), we: wr, wd: m_wd(sz, wd),
               rd: wr ? last_rd : m_rd(sz, sg, o, brd)});
      end

      chk("sb_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
